// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: accepts two DIGITS-wide operands over a
// valid/ready handshake, adds one digit pair per clock (LSD first) with a
// registered decimal carry, and hands back sum/carry-out over a second
// valid/ready handshake.
module bcd_serial_adder #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = $clog2(DIGITS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic [4*DIGITS-1:0]   b_bcd,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum_bcd,
  output logic                  cout,
  output logic                  err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);

  state_t               state_q;
  logic [4*DIGITS-1:0]  a_q;
  logic [4*DIGITS-1:0]  b_q;
  logic [4*DIGITS-1:0]  sum_q;
  logic [CNT_W-1:0]     idx_q;
  logic                 carry_q;
  logic                 cout_q;
  logic                 err_q;

  logic [3:0]           a_dig;
  logic [3:0]           b_dig;
  logic [4:0]           t_sum;
  logic [3:0]           digit_d;
  logic                 carry_d;
  logic [4*DIGITS-1:0]  sum_d;
  logic                 last_d;

  // True when any digit of either operand lies outside 0..9.
  function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] a,
                                         input logic [4*DIGITS-1:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9) bad = 1'b1;
      if (b[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Select the current digit pair, apply the decimal-adjusted add, and
  // merge the resulting digit into the running sum.
  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == CNT_W'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
    t_sum = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, carry_q};
    // (t+6) mod 16 equals t[3:0]+6 mod 16, so the 4-bit add is exact.
    if (t_sum > 5'd9) begin
      digit_d = t_sum[3:0] + 4'd6;
      carry_d = 1'b1;
    end else begin
      digit_d = t_sum[3:0];
      carry_d = 1'b0;
    end
    sum_d = sum_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == CNT_W'(i)) sum_d[4*i +: 4] = digit_d;
    end
    last_d = (idx_q == LAST_IDX);
  end

  // Control FSM plus operand/result registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a_bcd;
            b_q     <= b_bcd;
            carry_q <= cin;
            idx_q   <= '0;
            err_q   <= has_bad_digit(a_bcd, b_bcd);
            sum_q   <= '0;
            cout_q  <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
          idx_q   <= idx_q + CNT_W'(1);
          if (last_d) begin
            cout_q  <= carry_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum_bcd   = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=4): directed scenarios
// plus a few random legal-BCD operations, results checked via a scoreboard.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_bcd;
  logic [W-1:0] b_bcd;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_bcd;
  logic         cout;
  logic         err;
  logic         busy;

  int checks = 0;
  int passed = 0;
  exp_t sb[$];

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_bcd     (a_bcd),
    .b_bcd     (b_bcd),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_bcd   (sum_bcd),
    .cout      (cout),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model through plain integers: BCD -> decimal -> BCD.
  function automatic int bcd2int(input logic [W-1:0] v);
    int r;
    logic [W-1:0] tmp;
    r = 0;
    tmp = v;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(tmp[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W:0] int2bcd(input int v);
    logic [W:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    r[W] = (x != 0);
    return r;
  endfunction

  task automatic push_exp(input logic [W-1:0] s, input logic c, input logic e);
    exp_t x;
    x.sum = s;
    x.cout = c;
    x.err = e;
    sb.push_back(x);
  endtask

  // Counts edges after the accept edge until out_valid, then checks the
  // latency and compares the output against the scoreboard head.
  task automatic wait_result(input string tag);
    int cnt;
    exp_t x;
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      if (!out_valid) cnt++;
    end
    if (!out_valid) cnt = 99;
    chk({tag, "_latency"}, cnt, DIGITS);
    checks++;
    assert (sb.size() > 0) passed++;
    else $error("FAIL %s_sb_empty observed=0 expected=1", tag);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk({tag, "_sum"}, sum_bcd, x.sum);
      chk({tag, "_cout"}, cout, x.cout);
      chk({tag, "_err"}, err, x.err);
    end
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    a_bcd = a;
    b_bcd = b;
    cin = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic handoff(input string tag);
    logic [W-1:0] held;
    held = sum_bcd;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, in_ready, 1'b1);
    chk({tag, "_idle_ovalid"}, out_valid, 1'b0);
    chk({tag, "_idle_held"}, sum_bcd, held);
  endtask

  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic c, input logic [W-1:0] es, input logic ec, input logic ee);
    push_exp(es, ec, ee);
    accept(a, b, c);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_inrdy_run"}, in_ready, 1'b0);
    wait_result(tag);
    handoff(tag);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   rexp;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_bcd = '0;
    b_bcd = '0;
    cin = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sum", sum_bcd, '0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op("t1", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    op("t2", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op("t3", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);

    // Backpressure: result held while new operands wait on in_valid.
    push_exp(16'h0033, 1'b0, 1'b0);
    accept(16'h0011, 16'h0022, 1'b0);
    wait_result("t4a");
    a_bcd = 16'h4444;
    b_bcd = 16'h1111;
    cin = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_ovalid", out_valid, 1'b1);
      chk("t4_hold_inrdy", in_ready, 1'b0);
      chk("t4_hold_sum", sum_bcd, 16'h0033);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t4_idle_inrdy", in_ready, 1'b1);
    chk("t4_idle_sum", sum_bcd, 16'h0033);
    push_exp(16'h5555, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t4b_busy", busy, 1'b1);
    wait_result("t4b");
    handoff("t4b");

    op("t5", 16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1);

    // Reset mid-RUN discards the operation.
    accept(16'h1234, 16'h5678, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ovalid", out_valid, 1'b0);
    chk("t6_rst_sum", sum_bcd, '0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_inrdy", in_ready, 1'b1);
    chk("t6_rst_cout", cout, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    op("t6b", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);

    // Random legal-BCD operands against the integer model.
    for (int n = 0; n < 4; n++) begin
      for (int d = 0; d < DIGITS; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      rc = 1'($urandom_range(0, 1));
      rexp = int2bcd(bcd2int(ra) + bcd2int(rb) + int'(rc));
      op("rnd", ra, rb, rc, rexp[W-1:0], rexp[W], 1'b0);
    end

    checks++;
    assert (sb.size() == 0) passed++;
    else $error("FAIL sb_leftover observed=%0d expected=0", sb.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
